// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and constants for the pipeline sequencer
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        PC_HOLD  = 2'd0,
        PC_RUN   = 2'd1,
        PC_DRAIN = 2'd2,
        PC_HALT  = 2'd3
    } pc_state_t;

    localparam logic [31:0] NOP_IW = 32'h0000_0013;

    typedef struct packed {
        logic pc_stall;
        logic id_stall;
        logic ex_bubble;
        logic jump_take;
        logic if_flush;
        logic pipe_freeze;
        logic halted;
    } ctrl_strobes_t;

    localparam ctrl_strobes_t STROBES_IDLE = '0;

    // Whole-pipeline hold; every per-stage strobe is forced low underneath it.
    function automatic ctrl_strobes_t strobes_freeze(input logic is_halted);
        ctrl_strobes_t s;
        s             = STROBES_IDLE;
        s.pipe_freeze = 1'b1;
        s.halted      = is_halted;
        return s;
    endfunction

    function automatic ctrl_strobes_t strobes_stall();
        ctrl_strobes_t s;
        s           = STROBES_IDLE;
        s.pc_stall  = 1'b1;
        s.id_stall  = 1'b1;
        s.ex_bubble = 1'b1;
        return s;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_load_use.sv
// rtl/pipeline_ctrl_load_use.sv - load_use_detect: load in EX feeding a source of the ID instruction
module load_use_detect (
    input  logic [4:0] id_rs1_reg,
    input  logic [4:0] id_rs2_reg,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic       ex_is_load,
    input  logic [4:0] ex_wb_reg,
    input  logic       ex_wb_enable,
    output logic       hazard
);

    logic rs1_match;
    logic rs2_match;
    logic load_writes;

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_writes = ex_is_load & ex_wb_enable & (ex_wb_reg != 5'd0);
    assign rs1_match   = id_rs1_used & (id_rs1_reg == ex_wb_reg);
    assign rs2_match   = id_rs2_used & (id_rs2_reg == ex_wb_reg);
    assign hazard      = load_writes & (rs1_match | rs2_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - central stall/flush/freeze sequencer for the 5-stage RV32I pipeline
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int RESET_HOLD   = 2,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1_reg,
    input  logic [4:0]       id_rs2_reg,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_wb_reg,
    input  logic             ex_wb_enable,
    input  logic             jump_enable,
    input  logic             ebreak,
    input  logic             mem_busy,
    input  logic             resume,
    output logic             pc_stall,
    output logic             id_stall,
    output logic             ex_bubble,
    output logic             jump_take,
    output logic             if_flush,
    output logic             pipe_freeze,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [1:0]       state_out
);

    localparam int HOLD_W  = (RESET_HOLD   > 2) ? $clog2(RESET_HOLD)   : 1;
    localparam int DRAIN_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_INIT  = HOLD_W'(RESET_HOLD - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES - 1);

    pc_state_t          state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               resume_flush;
    logic               hazard;
    logic               count_en;
    ctrl_strobes_t      strb;

    load_use_detect u_load_use (
        .id_rs1_reg   (id_rs1_reg),
        .id_rs2_reg   (id_rs2_reg),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .ex_is_load   (ex_is_load),
        .ex_wb_reg    (ex_wb_reg),
        .ex_wb_enable (ex_wb_enable),
        .hazard       (hazard)
    );

    always_comb begin
        strb = STROBES_IDLE;
        unique case (state)
            PC_HOLD: strb = strobes_freeze(1'b0);
            PC_RUN: begin
                if (mem_busy) begin
                    strb = strobes_freeze(1'b0);
                end else if (resume_flush) begin
                    // First cycle after HALT: ID advances so the EBREAK retires, IF fetch is dropped.
                    strb.if_flush = 1'b1;
                end else if (hazard || ebreak) begin
                    strb = strobes_stall();
                end else if (jump_enable) begin
                    strb.jump_take = 1'b1;
                    strb.if_flush  = 1'b1;
                end
            end
            PC_DRAIN: strb = mem_busy ? strobes_freeze(1'b0) : strobes_stall();
            PC_HALT:  strb = strobes_freeze(1'b1);
            default:  strb = STROBES_IDLE;
        endcase
    end

    assign pc_stall    = strb.pc_stall;
    assign id_stall    = strb.id_stall;
    assign ex_bubble   = strb.ex_bubble;
    assign jump_take   = strb.jump_take;
    assign if_flush    = strb.if_flush;
    assign pipe_freeze = strb.pipe_freeze;
    assign halted      = strb.halted;
    assign state_out   = state;

    assign count_en = ((state == PC_RUN) || (state == PC_DRAIN)) &&
                      (strb.pc_stall || strb.pipe_freeze);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= PC_HOLD;
            hold_cnt     <= HOLD_INIT;
            drain_cnt    <= '0;
            resume_flush <= 1'b0;
            stall_count  <= '0;
        end else begin
            if (count_en && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + CNT_W'(1);
            end

            unique case (state)
                PC_HOLD: begin
                    if (hold_cnt == '0) begin
                        state <= PC_RUN;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                PC_RUN: begin
                    if (!mem_busy) begin
                        if (resume_flush) begin
                            resume_flush <= 1'b0;
                        end else if (!hazard && ebreak) begin
                            state     <= PC_DRAIN;
                            drain_cnt <= DRAIN_INIT;
                        end
                    end
                end
                PC_DRAIN: begin
                    if (!mem_busy) begin
                        if (drain_cnt == '0) begin
                            state <= PC_HALT;
                        end else begin
                            drain_cnt <= drain_cnt - DRAIN_W'(1);
                        end
                    end
                end
                PC_HALT: begin
                    if (resume) begin
                        state        <= PC_RUN;
                        resume_flush <= 1'b1;
                    end
                end
                default: state <= PC_HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1_reg, id_rs2_reg, ex_wb_reg;
    logic        id_rs1_used, id_rs2_used, ex_is_load, ex_wb_enable;
    logic        jump_enable, ebreak, mem_busy, resume;
    logic        pc_stall, id_stall, ex_bubble, jump_take, if_flush, pipe_freeze, halted;
    logic [31:0] stall_count;
    logic [1:0]  state_out;

    logic        s_reset;
    logic [4:0]  s_reg;
    logic        s_one, s_zero;
    logic        s_pc_stall, s_id_stall, s_ex_bubble, s_jump_take, s_if_flush, s_pipe_freeze, s_halted;
    logic [3:0]  s_count;
    logic [1:0]  s_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk(clk), .reset(reset),
        .id_rs1_reg(id_rs1_reg), .id_rs2_reg(id_rs2_reg),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_is_load(ex_is_load), .ex_wb_reg(ex_wb_reg), .ex_wb_enable(ex_wb_enable),
        .jump_enable(jump_enable), .ebreak(ebreak), .mem_busy(mem_busy), .resume(resume),
        .pc_stall(pc_stall), .id_stall(id_stall), .ex_bubble(ex_bubble),
        .jump_take(jump_take), .if_flush(if_flush), .pipe_freeze(pipe_freeze),
        .halted(halted), .stall_count(stall_count), .state_out(state_out)
    );

    pipeline_ctrl #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(s_reset),
        .id_rs1_reg(s_reg), .id_rs2_reg(s_reg),
        .id_rs1_used(s_one), .id_rs2_used(s_zero),
        .ex_is_load(s_one), .ex_wb_reg(s_reg), .ex_wb_enable(s_one),
        .jump_enable(s_zero), .ebreak(s_zero), .mem_busy(s_zero), .resume(s_zero),
        .pc_stall(s_pc_stall), .id_stall(s_id_stall), .ex_bubble(s_ex_bubble),
        .jump_take(s_jump_take), .if_flush(s_if_flush), .pipe_freeze(s_pipe_freeze),
        .halted(s_halted), .stall_count(s_count), .state_out(s_state)
    );

    // ---------------- behavioural model ----------------
    // mode: 0 hold, 1 run, 2 drain, 3 halt
    bit      m_valid = 0;
    int      m_mode, m_hold_left, m_drain_left;
    bit      m_resumed;
    longint  m_count;

    function automatic bit load_use();
        return ex_is_load && ex_wb_enable && (ex_wb_reg != 5'd0) &&
               ((id_rs1_used && id_rs1_reg == ex_wb_reg) || (id_rs2_used && id_rs2_reg == ex_wb_reg));
    endfunction

    // {pc_stall,id_stall,ex_bubble,jump_take,if_flush,pipe_freeze,halted}
    function automatic logic [6:0] model_out(int mode, bit resumed);
        if (mode == 0) return 7'b0000010;
        if (mode == 3) return 7'b0000011;
        if (mem_busy) return 7'b0000010;
        if (mode == 2) return 7'b1110000;
        if (resumed) return 7'b0000100;
        if (load_use() || ebreak) return 7'b1110000;
        if (jump_enable) return 7'b0001100;
        return 7'b0000000;
    endfunction

    always @(posedge clk) begin
        logic [6:0] o;
        if (!reset) begin
            m_valid = 1; m_mode = 0; m_hold_left = 2; m_drain_left = 0;
            m_resumed = 0; m_count = 0;
        end else if (m_valid) begin
            o = model_out(m_mode, m_resumed);
            if ((m_mode == 1 || m_mode == 2) && (o[6] || o[1]) && m_count < 64'hFFFF_FFFF)
                m_count++;
            case (m_mode)
                0: begin m_hold_left--; if (m_hold_left == 0) m_mode = 1; end
                1: if (!mem_busy) begin
                       if (m_resumed) m_resumed = 0;
                       else if (!load_use() && ebreak) begin m_mode = 2; m_drain_left = 3; end
                   end
                2: if (!mem_busy) begin m_drain_left--; if (m_drain_left == 0) m_mode = 3; end
                default: if (resume) begin m_mode = 1; m_resumed = 1; end
            endcase
        end
    end

    always @(negedge clk) begin
        logic [6:0] e;
        logic [6:0] a;
        if (m_valid) begin
            e = model_out(m_mode, m_resumed);
            a = {pc_stall, id_stall, ex_bubble, jump_take, if_flush, pipe_freeze, halted};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL model_strobes t=%0t got=%b want=%b", $time, a, e);
            end
            checks++;
            if (state_out !== 2'(m_mode)) begin
                errors++;
                $display("FAIL model_state t=%0t got=%0d want=%0d", $time, state_out, m_mode);
            end
            checks++;
            if (stall_count !== 32'(m_count)) begin
                errors++;
                $display("FAIL model_count t=%0t got=%0d want=%0d", $time, stall_count, m_count);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_in();
        id_rs1_reg = 0; id_rs2_reg = 0; ex_wb_reg = 0;
        id_rs1_used = 0; id_rs2_used = 0; ex_is_load = 0; ex_wb_enable = 0;
        jump_enable = 0; ebreak = 0; mem_busy = 0; resume = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        logic [5:0] busy_pat;
        logic [5:0] frz_pat;
        logic [1:0] st_pat [6];
        st_pat = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3};
        busy_pat = 6'b000110;
        frz_pat  = 6'b100110;

        clear_in();
        reset = 1'b0;
        s_reset = 1'b0; s_reg = 5'd9; s_one = 1'b1; s_zero = 1'b0;

        cyc(3);
        reset = 1'b1;
        settle();
        chk("hold_c1_freeze", pipe_freeze, 1);
        chk("hold_c1_state", state_out, 0);
        cyc(); settle();
        chk("hold_c2_freeze", pipe_freeze, 1);
        cyc(); settle();
        chk("run_c3_state", state_out, 1);
        chk("run_c3_freeze", pipe_freeze, 0);
        chk("run_c3_count", stall_count, 0);

        // load-use on rs2
        ex_is_load = 1; ex_wb_enable = 1; ex_wb_reg = 5; id_rs2_used = 1; id_rs2_reg = 5;
        settle();
        chk("lu_stalls", {pc_stall, id_stall, ex_bubble}, 3'b111);
        cyc(); clear_in(); settle();
        chk("lu_count", stall_count, 1);
        chk("lu_released", pc_stall, 0);

        // load to x0 is not a hazard
        ex_is_load = 1; ex_wb_enable = 1; ex_wb_reg = 0; id_rs1_used = 1; id_rs1_reg = 0;
        settle();
        chk("x0_no_stall", pc_stall, 0);
        cyc(); clear_in();

        // hazard beats jump, jump taken next cycle
        ex_is_load = 1; ex_wb_enable = 1; ex_wb_reg = 7; id_rs1_used = 1; id_rs1_reg = 7; jump_enable = 1;
        settle();
        chk("hz_jump_blocked", {jump_take, pc_stall}, 2'b01);
        cyc(); ex_is_load = 0; settle();
        chk("jump_after_hz", {jump_take, if_flush}, 2'b11);
        cyc(); clear_in();

        // ebreak -> 3 drain cycles -> halt
        ebreak = 1; settle();
        chk("ebreak_bubble", ex_bubble, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(); settle();
            chk("drain_state", state_out, 2);
        end
        cyc(); jump_enable = 1; settle();
        chk("halt_halted", halted, 1);
        chk("halt_count", stall_count, 6);
        chk("halt_no_jump", jump_take, 0);
        cyc(); jump_enable = 0; resume = 1; settle();
        chk("halt_resume_cycle", halted, 1);
        cyc(); resume = 0; settle();
        chk("resume_state", state_out, 1);
        chk("resume_flush", {if_flush, halted, id_stall}, 3'b100);
        cyc(); ebreak = 0;

        // resume outside HALT is ignored
        resume = 1; settle();
        chk("stray_resume", if_flush, 0);
        cyc(); resume = 0; settle();
        chk("stray_resume_state", state_out, 1);

        // mem_busy outranks hazard and jump
        ex_is_load = 1; ex_wb_enable = 1; ex_wb_reg = 3; id_rs1_used = 1; id_rs1_reg = 3;
        jump_enable = 1; mem_busy = 1; settle();
        chk("busy_freeze_only", {pc_stall, id_stall, ex_bubble, jump_take, if_flush, pipe_freeze}, 6'b000001);
        cyc(); clear_in(); settle();
        chk("busy_count", stall_count, 7);

        // mem_busy stretches drain by two cycles
        ebreak = 1;
        for (int i = 0; i < 6; i++) begin
            cyc(); mem_busy = busy_pat[i]; settle();
            chk("drain_busy_state", state_out, st_pat[i]);
            chk("drain_busy_freeze", pipe_freeze, frz_pat[i]);
        end

        // reset from HALT
        ebreak = 0; mem_busy = 0;
        do_reset(); settle();
        chk("rst_halt_state", state_out, 0);
        chk("rst_halt_count", stall_count, 0);
        cyc(2);

        // reset from DRAIN
        ebreak = 1; cyc(); ebreak = 0; settle();
        chk("pre_rst_drain", state_out, 2);
        do_reset(); settle();
        chk("rst_drain_state", state_out, 0);
        chk("rst_drain_count", stall_count, 0);
        cyc(3);

        // 4-bit counter under a permanent hazard
        s_reset = 1'b1;
        cyc(2); settle();
        chk("sat_run", s_state, 1);
        cyc(5); settle();
        chk("sat_count5", s_count, 5);
        cyc(20); settle();
        chk("sat_count15", s_count, 15);
        cyc(10); settle();
        chk("sat_stuck", s_count, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
